add_seq_ctrl: RTL and testbench

Sequencer that performs W-bit add/subtract by time-multiplexing one 4-bit `adder` over NIBBLES cycles, LSB nibble first, with the carry held in a register between cycles. It sits between a requesting master (start/busy/done handshake) and the 4-bit ripple datapath. This lets wide arithmetic reuse the small adder instead of replicating it.

---
 rtl/add_seq_pkg.sv | 17 +
 rtl/adder.sv | 22 ++
 rtl/add_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_add_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// -----------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the nibble-serial add/subtract sequencer.
//   NIBBLE_W : width of the one shared ripple adder slice
//   state_t  : controller states (IDLE -> RUN -> DONE -> IDLE)
// -----------------------------------------------------------------------------
package add_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// 4-bit ripple adder slice shared by the sequencer.
// Ports:
//   a, b  in  NIBBLE_W  operand slices
//   cin   in  1         carry in
//   c     out NIBBLE_W  sum slice
//   cout  out 1         carry out
// -----------------------------------------------------------------------------
module adder
    import add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] c,
    output logic                cout
);

    assign {cout, c} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
// W-bit add/subtract (W = 4*NIBBLES) performed over NIBBLES cycles through a
// single 4-bit adder, LSB nibble first, carry held in a register between
// cycles. Requesting master uses a start / busy / done handshake.
// Ports:
//   clk     in  1  rising-edge clock
//   rst_n   in  1  asynchronous active-low reset
//   start   in  1  request, sampled only in IDLE
//   op_sub  in  1  0 = a+b+cin, 1 = a-b
//   cin     in  1  carry-in for add (ignored for subtract)
//   a, b    in  W  operands, sampled with start
//   busy    out 1  operation in progress
//   done    out 1  one-cycle pulse, result valid
//   sum     out W  result, held until next completion
//   cout    out 1  carry out of MSB (subtract: 1 = no borrow)
//   ovf     out 1  signed overflow
// -----------------------------------------------------------------------------
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        op_sub,
    input  logic                        cin,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int unsigned   IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t                           r_state;
    state_t                           w_state_nxt;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] r_b;      // already inverted for subtract
    logic [NIBBLES-1:0][NIBBLE_W-1:0] r_part;   // partial sum being assembled
    logic                             r_carry;
    logic [IW-1:0]                    r_idx;
    logic [NIBBLE_W*NIBBLES-1:0]      r_sum;
    logic                             r_cout;
    logic                             r_ovf;

    logic [NIBBLE_W-1:0]              w_nib_a;
    logic [NIBBLE_W-1:0]              w_nib_b;
    logic [NIBBLE_W-1:0]              w_nib_s;
    logic                             w_nib_cout;
    logic                             w_last;
    logic                             w_c_msb;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] w_result;

    assign w_nib_a = r_a[r_idx];
    assign w_nib_b = r_b[r_idx];
    assign w_last  = (r_idx == LAST_IDX);

    // Carry into the top bit, recovered from the slice's own bit-3 sum.
    assign w_c_msb = w_nib_a[NIBBLE_W-1] ^ w_nib_b[NIBBLE_W-1] ^ w_nib_s[NIBBLE_W-1];

    adder u_adder (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .c    (w_nib_s),
        .cout (w_nib_cout)
    );

    // The top nibble is merged in on the fly so the visible result updates on
    // the same edge that enters DONE.
    always_comb begin
        w_result              = r_part;
        w_result[NIBBLES-1]   = w_nib_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= op_sub ? ~b : b;
                        r_carry <= op_sub | cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_part[r_idx] <= w_nib_s;
                    r_carry       <= w_nib_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_sum  <= w_result;
                        r_cout <= w_nib_cout;
                        r_ovf  <= w_c_msb ^ w_nib_cout;
                    end else begin
                        r_idx  <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_seq_ctrl
// Self-checking bench for add_seq_ctrl. A timeline model computes each result
// with full-width arithmetic at acceptance and publishes it NIBBLES edges later.
// -----------------------------------------------------------------------------
module tb_add_seq_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         start  = 1'b0;
    logic         op_sub = 1'b0;
    logic         cin    = 1'b0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left: cycles remaining until the op is fully retired
    //   >= 2 : busy, 1 : done cycle with new result visible, 0 : idle
    int           m_left = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;
    logic [W-1:0] mb;
    logic [W:0]   mfull;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_sum  = p_sum;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end else if (start) begin
            mb     = op_sub ? ~b : b;
            mfull  = {1'b0, a} + {1'b0, mb} + {{W{1'b0}}, (op_sub | cin)};
            p_sum  = mfull[W-1:0];
            p_cout = mfull[W];
            p_ovf  = (a[W-1] == mb[W-1]) && (mfull[W-1] != a[W-1]);
            m_left = NIBBLES + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_left >= 2));
            check("done", 64'(done), 64'(m_left == 1));
            check("sum",  64'(sum),  64'(m_sum));
            check("cout", 64'(cout), 64'(m_cout));
            check("ovf",  64'(ovf),  64'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic run_op(input string name, input logic s, input logic c,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit hammer);
        int lat;
        int extra;
        step();
        start  = 1'b1;
        op_sub = s;
        cin    = c;
        a      = av;
        b      = bv;
        lat    = 0;
        do begin
            step();
            lat++;
            // operands scrambled after acceptance must not matter
            start  = hammer;
            op_sub = 1'($urandom);
            cin    = 1'($urandom);
            a      = W'($urandom);
            b      = W'($urandom);
        end while (m_left != 1 && lat < 4 * NIBBLES + 8);
        start = 1'b0;
        check({name, "_latency"},  64'(lat),  64'(NIBBLES + 1));
        check({name, "_done"},     64'(done), 64'(1));
        check({name, "_sum"},      64'(sum),  64'(es));
        check({name, "_cout"},     64'(cout), 64'(ec));
        check({name, "_ovf"},      64'(ovf),  64'(eo));
        check({name, "_model_sum"},64'(m_sum),64'(es));
        check({name, "_model_flags"}, 64'({m_cout, m_ovf}), 64'({ec, eo}));
        if (hammer) begin
            extra = 0;
            repeat (NIBBLES + 3) begin
                step();
                if (done) extra++;
            end
            check({name, "_extra_done"}, 64'(extra), 64'(0));
        end
    endtask

    initial begin
        int dcount;
        int last_done;
        #1;
        rst_n  = 1'b0;
        chk_en = 1'b1;
        step();
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_sum",  64'(sum),  64'(0));
        check("reset_flags",64'({cout, ovf}), 64'(0));
        step();
        rst_n = 1'b1;

        run_op("add_1234_0fff", 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("add_ffff_0001", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("add_7fff_0001", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_5_7",       1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_8000_1",    1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("add_0_0_cin",   1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);

        // reset during the second RUN cycle
        step();
        start = 1'b1;
        a     = 16'hABCD;
        b     = 16'h1111;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum",  64'(sum),  64'(0));
        check("abort_flags",64'({cout, ovf}), 64'(0));
        step();
        step();
        rst_n  = 1'b1;
        dcount = 0;
        repeat (NIBBLES + 4) begin
            step();
            if (done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'(0));
        run_op("post_abort", 1'b0, 1'b0, 16'h00F0, 16'h0F10, 16'h1000, 1'b0, 1'b0, 1'b0);

        // back-to-back with start held high
        step();
        last_done = -1;
        dcount    = 0;
        for (int i = 0; i < 8 * (NIBBLES + 2); i++) begin
            start  = 1'b1;
            op_sub = 1'($urandom);
            cin    = 1'($urandom);
            a      = pick();
            b      = pick();
            step();
            if (done) begin
                if (last_done >= 0) check("b2b_gap", 64'(i - last_done), 64'(NIBBLES + 2));
                last_done = i;
                dcount++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(dcount >= 7), 64'(1));
        repeat (NIBBLES + 3) step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            op_sub = 1'($urandom);
            cin    = 1'($urandom);
            a      = pick();
            b      = pick();
            step();
        end
        start = 1'b0;
        repeat (NIBBLES + 3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
